// File: rtl/logic_pkg.sv
// Shared constants and helpers for the logic-library counter and shift blocks.
// Shift-direction encodings and the counter-width helper live here so successor blocks agree on them.
package logic_pkg;

    localparam bit SHIFT_MSB_FIRST = 1'b0;
    localparam bit SHIFT_LSB_FIRST = 1'b1;

    // Bits needed to hold values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/frame_counter.sv
// Modulo-MODULUS event counter: o_wrap flags the increment that completes a frame,
// o_done is that flag registered into a one-cycle pulse.
module frame_counter #(
    parameter int MODULUS = 8,
    parameter int CW      = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_wrap,
    output logic o_done
);

    logic [CW-1:0] r_count;
    logic          r_done;
    logic          w_wrap;

    // Clear dominates increment, so an aborted frame can never wrap.
    assign w_wrap = i_inc && !i_clr && (r_count == CW'(MODULUS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_wrap;
            if (i_clr) begin
                r_count <= '0;
            end else if (i_inc) begin
                r_count <= w_wrap ? '0 : r_count + 1'b1;
            end
        end
    end

    assign o_wrap = w_wrap;
    assign o_done = r_done;

endmodule

// File: rtl/shift_latch_reg.sv
// Serial/parallel shift register with a storage (output latch) stage, frame counter and
// cascade output; generalises the 74164/74165/74595 family.
module shift_latch_reg
    import logic_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit LSB_FIRST  = SHIFT_MSB_FIRST,
    parameter bit AUTO_LATCH = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclr_n,
    input  logic             load_en,
    input  logic [WIDTH-1:0] par_in,
    input  logic             shift_en,
    input  logic             ser_in,
    input  logic             latch_en,
    input  logic             oe_n,
    output logic [WIDTH-1:0] q,
    output logic             q_en,
    output logic             ser_out,
    output logic             frame_done
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap;
    logic             w_done;

    always_comb begin
        if (LSB_FIRST == SHIFT_LSB_FIRST) begin
            w_shifted = {ser_in, r_shift[WIDTH-1:1]};
        end else begin
            w_shifted = {r_shift[WIDTH-2:0], ser_in};
        end
    end

    always_comb begin
        w_next = r_shift;
        if (!sclr_n) begin
            w_next = '0;
        end else if (load_en) begin
            w_next = par_in;
        end else if (shift_en) begin
            w_next = w_shifted;
        end
    end

    frame_counter #(
        .MODULUS (WIDTH),
        .CW      (CW)
    ) u_frame_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (!sclr_n || load_en),
        .i_inc  (shift_en),
        .o_wrap (w_wrap),
        .o_done (w_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
        end else begin
            r_shift <= w_next;
        end
    end

    // A manual latch takes the pre-edge shift stage (74595 tied-clock lag); the auto-latch
    // takes the completed frame and wins when both happen on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (AUTO_LATCH && w_wrap) begin
            r_q <= w_next;
        end else if (latch_en) begin
            r_q <= r_shift;
        end
    end

    assign q          = r_q;
    assign q_en       = ~oe_n;
    assign ser_out    = (LSB_FIRST == SHIFT_LSB_FIRST) ? r_shift[0] : r_shift[WIDTH-1];
    assign frame_done = w_done;

endmodule

// File: tb/tb_shift_latch_reg.sv
// Bench for shift_latch_reg: three instances (MSB-first, MSB-first auto-latch, LSB-first)
// share one directed stimulus stream and are checked against a bench-side model each cycle.
module tb_shift_latch_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sclr_n = 1'b1;
  logic       load_en = 1'b0;
  logic [7:0] par_in = 8'h00;
  logic       shift_en = 1'b0;
  logic       ser_in = 1'b0;
  logic       latch_en = 1'b0;
  logic       oe_n = 1'b0;

  logic [7:0] q_a, q_b, q_c;
  logic       q_en_a, q_en_b, q_en_c;
  logic       so_a, so_b, so_c;
  logic       fd_a, fd_b, fd_c;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  shift_latch_reg #(.WIDTH(8), .LSB_FIRST(1'b0), .AUTO_LATCH(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .sclr_n(sclr_n), .load_en(load_en), .par_in(par_in),
    .shift_en(shift_en), .ser_in(ser_in), .latch_en(latch_en), .oe_n(oe_n),
    .q(q_a), .q_en(q_en_a), .ser_out(so_a), .frame_done(fd_a));

  shift_latch_reg #(.WIDTH(8), .LSB_FIRST(1'b0), .AUTO_LATCH(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .sclr_n(sclr_n), .load_en(load_en), .par_in(par_in),
    .shift_en(shift_en), .ser_in(ser_in), .latch_en(latch_en), .oe_n(oe_n),
    .q(q_b), .q_en(q_en_b), .ser_out(so_b), .frame_done(fd_b));

  shift_latch_reg #(.WIDTH(8), .LSB_FIRST(1'b1), .AUTO_LATCH(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .sclr_n(sclr_n), .load_en(load_en), .par_in(par_in),
    .shift_en(shift_en), .ser_in(ser_in), .latch_en(latch_en), .oe_n(oe_n),
    .q(q_c), .q_en(q_en_c), .ser_out(so_c), .frame_done(fd_c));

  logic [7:0] d_q [3];
  logic       d_qen [3];
  logic       d_so [3];
  logic       d_fd [3];
  assign d_q[0] = q_a;     assign d_q[1] = q_b;     assign d_q[2] = q_c;
  assign d_qen[0] = q_en_a; assign d_qen[1] = q_en_b; assign d_qen[2] = q_en_c;
  assign d_so[0] = so_a;   assign d_so[1] = so_b;   assign d_so[2] = so_c;
  assign d_fd[0] = fd_a;   assign d_fd[1] = fd_b;   assign d_fd[2] = fd_c;

  // ---------------- scoreboard compare ----------------
  task automatic cmp(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Shift stage held as an integer 0..255, frame position as a plain shift count.
  int         m_sh [3];
  int         m_q [3];
  int         m_cnt [3];
  bit         m_fd [3];

  function automatic bit cfg_lsb(input int k);
    return k == 2;
  endfunction

  function automatic bit cfg_auto(input int k);
    return k == 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_sh[k] <= 0; m_q[k] <= 0; m_cnt[k] <= 0; m_fd[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        int pre, nxt, c;
        bit wrap;
        pre = m_sh[k];
        nxt = pre;
        c = m_cnt[k];
        wrap = 1'b0;
        if (!sclr_n) begin
          nxt = 0; c = 0;
        end else if (load_en) begin
          nxt = int'(par_in); c = 0;
        end else if (shift_en) begin
          if (cfg_lsb(k)) nxt = pre / 2 + int'(ser_in) * 128;
          else            nxt = (pre * 2 + int'(ser_in)) % 256;
          c = c + 1;
          if (c == 8) begin
            c = 0; wrap = 1'b1;
          end
        end
        m_sh[k]  <= nxt;
        m_cnt[k] <= c;
        m_fd[k]  <= wrap;
        if (cfg_auto(k) && wrap) m_q[k] <= nxt;
        else if (latch_en)       m_q[k] <= pre;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      cmp("q", k, d_q[k], 8'(m_q[k]));
      cmp("ser_out", k, {7'b0, d_so[k]},
          {7'b0, cfg_lsb(k) ? (m_sh[k] % 2 == 1) : (m_sh[k] >= 128)});
      cmp("frame_done", k, {7'b0, d_fd[k]}, {7'b0, m_fd[k]});
      cmp("q_en", k, {7'b0, d_qen[k]}, {7'b0, ~oe_n});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sclr_n = 1'b1; load_en = 1'b0; shift_en = 1'b0; ser_in = 1'b0; latch_en = 1'b0;
  endtask

  task automatic do_shift(input logic b, input logic lat);
    shift_en = 1'b1; ser_in = b; latch_en = lat;
    cyc();
    idle_inputs();
  endtask

  task automatic do_load(input logic [7:0] v, input logic sh);
    load_en = 1'b1; par_in = v; shift_en = sh; ser_in = 1'b1;
    cyc();
    idle_inputs();
  endtask

  task automatic do_latch();
    latch_en = 1'b1;
    cyc();
    idle_inputs();
  endtask

  task automatic do_clear(input logic lat);
    sclr_n = 1'b0; latch_en = lat;
    cyc();
    idle_inputs();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] pat;
    logic [7:0] pat2;
    int nfd;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp("reset_q", 0, q_a, 8'h00);
    cmp("reset_fd", 0, {7'b0, fd_a}, 8'h00);

    // Asynchronous reset mid-frame
    do_load(8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) do_shift(1'b1, 1'b0);
    do_latch();
    cmp("pre_reset_q", 0, q_a, 8'hFF);
    #2 rst_n = 1'b0;
    #1;
    cmp("async_q", 0, q_a, 8'h00);
    cmp("async_ser_out", 0, {7'b0, so_a}, 8'h00);
    cmp("async_fd", 0, {7'b0, fd_a}, 8'h00);
    rst_n = 1'b1;
    nfd = 0;
    for (int i = 0; i < 8; i++) begin
      do_shift(1'b1, 1'b0);
      nfd += int'(fd_a);
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      nfd += int'(fd_a);
    end
    cmp("post_reset_frames", 0, 8'(nfd), 8'd1);

    // MSB-first 0xA5, latch one cycle later, then cascade out
    do_clear(1'b0);
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) do_shift(pat[7-i], 1'b0);
    do_latch();
    cmp("latch_A5", 0, q_a, 8'hA5);
    cmp("auto_A5", 1, q_b, 8'hA5);
    for (int i = 0; i < 8; i++) begin
      cmp("cascade_bit", 0, {7'b0, so_a}, {7'b0, pat[7-i]});
      do_shift(1'b0, 1'b0);
    end

    // Auto-latch, back-to-back frames 0x3C then 0xC3
    do_clear(1'b0);
    pat = 8'h3C;
    pat2 = 8'hC3;
    for (int i = 0; i < 16; i++) begin
      do_shift((i < 8) ? pat[7-i] : pat2[15-i], 1'b0);
      cmp("auto_fd_pulse", 1, {7'b0, fd_b}, {7'b0, (i == 7 || i == 15)});
      if (i == 7)  cmp("auto_q_frame1", 1, q_b, 8'h3C);
      if (i == 12) cmp("auto_q_hold", 1, q_b, 8'h3C);
      if (i == 15) cmp("auto_q_frame2", 1, q_b, 8'hC3);
    end
    cyc();
    cmp("auto_fd_end", 1, {7'b0, fd_b}, 8'h00);

    // Load beats shift; counter restarts
    do_shift(1'b1, 1'b0);
    do_load(8'h81, 1'b1);
    do_latch();
    cmp("load_wins", 0, q_a, 8'h81);
    nfd = 0;
    for (int i = 0; i < 8; i++) begin
      do_shift(1'b0, 1'b0);
      nfd += int'(fd_a);
    end
    cyc();
    nfd += int'(fd_a);
    cmp("load_frames", 0, 8'(nfd), 8'd1);
    do_latch();
    cmp("load_drained", 0, q_a, 8'h00);

    // Latch lag during a shift, and latch with clear
    do_clear(1'b0);
    do_shift(1'b1, 1'b0);
    do_shift(1'b1, 1'b1);
    cmp("latch_lag", 0, q_a, 8'h01);
    do_load(8'h5A, 1'b0);
    do_clear(1'b1);
    cmp("clear_latch", 0, q_a, 8'h5A);
    do_latch();
    cmp("cleared_stage", 0, q_a, 8'h00);

    // LSB-first 0x96, output enable
    pat = 8'h96;
    for (int i = 0; i < 8; i++) do_shift(pat[i], 1'b0);
    do_latch();
    cmp("lsb_first", 2, q_c, 8'h96);
    oe_n = 1'b1;
    #1;
    cmp("oe_off", 2, {7'b0, q_en_c}, 8'h00);
    cmp("oe_off_q", 2, q_c, 8'h96);
    oe_n = 1'b0;
    #1;
    cmp("oe_on", 2, {7'b0, q_en_c}, 8'h01);

    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
